morse_encoder_param: RTL and testbench

MORSE_ENCODER_PARAM -- requirements
Module: morse_encoder_param

---
 rtl/morse_encoder_param.sv | 172 +++++++++++++++++
 tb/tb_morse_encoder_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder_param.sv
// Morse character transmitter: latches a dot/dash pattern and plays it on led
// with unit-timed marks, intra-character spaces and a trailing character gap.
module morse_encoder_param #(
   parameter int MAX_LEN     = 6,
   parameter int UNIT_CYCLES = 25000000,
   parameter int DASH_UNITS  = 3,
   parameter int GAP_UNITS   = 3,
   parameter int LW          = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   input  logic               repeat_en,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LW-1:0]      len,
   output logic               led,
   output logic               busy,
   output logic               done
);

   // Counter is sized for the longest single state so it can never wrap.
   localparam int MAX_UNITS  = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
   localparam int MAX_UNITS1 = (MAX_UNITS > 1) ? MAX_UNITS : 1;
   localparam int CNT_TOP    = MAX_UNITS1 * UNIT_CYCLES;
   localparam int CW         = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

   localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_LAST = CW'(DASH_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_UNITS * UNIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      LGAP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [MAX_LEN-1:0]   shreg_q, shreg_d;
   logic [LW-1:0]        rem_q, rem_d;
   logic [MAX_LEN-1:0]   pat_q, pat_d;
   logic [LW-1:0]        len_q, len_d;
   logic                 led_q, led_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [LW-1:0]        len_clamped;
   logic [CW-1:0]        mark_last;

   always_comb begin
      len_clamped = len;
      if (len > LW'(MAX_LEN)) begin
         len_clamped = LW'(MAX_LEN);
      end
   end

   // The symbol currently on air is always the MSB of the working shift register.
   assign mark_last = shreg_q[MAX_LEN-1] ? DASH_LAST : DOT_LAST;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      shreg_d = shreg_q;
      rem_d   = rem_q;
      pat_d   = pat_q;
      len_d   = len_q;
      led_d   = led_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start && (len != '0)) begin
               pat_d   = pattern;
               len_d   = len_clamped;
               shreg_d = pattern;
               rem_d   = len_clamped;
               state_d = MARK;
               led_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end

         MARK: begin
            if (cnt_q == mark_last) begin
               cnt_d   = '0;
               led_d   = 1'b0;
               state_d = (rem_q == LW'(1)) ? LGAP : SPACE;
            end
         end

         SPACE: begin
            if (cnt_q == DOT_LAST) begin
               cnt_d   = '0;
               shreg_d = shreg_q << 1;
               rem_d   = rem_q - LW'(1);
               led_d   = 1'b1;
               state_d = MARK;
            end
         end

         LGAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (repeat_en) begin
                  shreg_d = pat_q;
                  rem_d   = len_q;
                  led_d   = 1'b1;
                  state_d = MARK;
               end else begin
                  led_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            cnt_d   = '0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything else, including a simultaneous start.
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         led_d   = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         shreg_d = shreg_q;
         rem_d   = rem_q;
         pat_d   = pat_q;
         len_d   = len_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         rem_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign led  = led_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_morse_encoder_param.sv
// Directed bench for morse_encoder_param with a 4-cycle unit: checks led/busy/done
// cycle by cycle against hand-written segment tables for each character.
module tb_morse_encoder_param;

   localparam int MAX_LEN = 6;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic               clk;
   logic               resetn;
   logic               start;
   logic               abort;
   logic               repeat_en;
   logic [MAX_LEN-1:0] pattern;
   logic [LW-1:0]      len;
   logic               led;
   logic               busy;
   logic               done;

   int checks   = 0;
   int failures = 0;

   morse_encoder_param #(
      .MAX_LEN     (6),
      .UNIT_CYCLES (4),
      .DASH_UNITS  (3),
      .GAP_UNITS   (3)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .abort     (abort),
      .repeat_en (repeat_en),
      .pattern   (pattern),
      .len       (len),
      .led       (led),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // n cycles of led==v while busy and without a done pulse; ends on a negedge
   task automatic seg(input string tag, input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_led"}, {31'd0, led}, {31'd0, v});
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
         @(negedge clk);
      end
   endtask

   task automatic idle_for(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_led"}, {31'd0, led}, 32'd0);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
         chk({tag, "_done"}, {31'd0, done}, 32'd0);
         @(negedge clk);
      end
   endtask

   task automatic pulse_start(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l);
      pattern = p;
      len     = l;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic expect_done(input string tag);
      chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
      chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_led"}, {31'd0, led}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
      $display("char %s complete at %0t", tag, $time);
   endtask

   initial begin
      resetn    = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      repeat_en = 1'b0;
      pattern   = '0;
      len       = '0;
      #1;
      chk("rst_led", {31'd0, led}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // len==0 is ignored
      pulse_start(6'b101010, 3'd0);
      idle_for("len0", 4);
      $display("char len0 ignored");

      // abort beats a simultaneous start
      abort = 1'b1;
      pulse_start(6'b010000, 3'd2);
      abort = 1'b0;
      idle_for("abort_start", 3);

      // 'A' = dot dash
      pulse_start(6'b010000, 3'd2);
      seg("A_m1", 1'b1, 4);
      seg("A_s1", 1'b0, 4);
      seg("A_m2", 1'b1, 12);
      seg("A_gap", 1'b0, 12);
      expect_done("A");

      // 'E' = dot; inputs change and a second start arrives while busy
      pulse_start(6'b000000, 3'd1);
      pattern = 6'b111111;
      len     = 3'd6;
      seg("E_m1a", 1'b1, 2);
      start = 1'b1;
      seg("E_m1b", 1'b1, 1);
      start = 1'b0;
      seg("E_m1c", 1'b1, 1);
      seg("E_gap", 1'b0, 12);
      expect_done("E");
      idle_for("E_after", 3);

      // 'T' looped with repeat_en, then released during the second gap
      repeat_en = 1'b1;
      pulse_start(6'b100000, 3'd1);
      seg("T_m1", 1'b1, 12);
      seg("T_g1", 1'b0, 12);
      seg("T_m2", 1'b1, 12);
      seg("T_g2a", 1'b0, 6);
      repeat_en = 1'b0;
      seg("T_g2b", 1'b0, 6);
      expect_done("T");

      // abort during the dash of 'A'
      pulse_start(6'b010000, 3'd2);
      seg("Ab_m1", 1'b1, 4);
      seg("Ab_s1", 1'b0, 4);
      seg("Ab_m2", 1'b1, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      idle_for("Ab_idle", 20);
      $display("char A aborted at %0t", $time);

      pulse_start(6'b010000, 3'd2);
      seg("A2_m1", 1'b1, 4);
      seg("A2_s1", 1'b0, 4);
      seg("A2_m2", 1'b1, 12);
      seg("A2_gap", 1'b0, 12);
      expect_done("A2");

      // len=7 clamps to six dashes
      pulse_start(6'b111111, 3'd7);
      for (int k = 0; k < 5; k++) begin
         seg("C_mark", 1'b1, 12);
         seg("C_space", 1'b0, 4);
      end
      seg("C_mark6", 1'b1, 12);
      seg("C_gap", 1'b0, 12);
      expect_done("clamp");

      // asynchronous reset in the middle of a SPACE
      pulse_start(6'b010000, 3'd2);
      seg("R_m1", 1'b1, 4);
      seg("R_s1", 1'b0, 2);
      resetn = 1'b0;
      #1;
      chk("rst_async_led", {31'd0, led}, 32'd0);
      chk("rst_async_busy", {31'd0, busy}, 32'd0);
      chk("rst_async_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      idle_for("R_idle", 40);
      $display("char A reset mid-space at %0t", $time);

      pulse_start(6'b000000, 3'd1);
      seg("E2_m1", 1'b1, 4);
      seg("E2_gap", 1'b0, 12);
      expect_done("E2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
